// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow square wave in clk cycles.
// Results leave through a valid/ready port; timeout and overrun are sticky flags.
// Optional min/max period tracking is enabled with `define PERIOD_METER_MINMAX_EN.
module period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_ready,
`ifdef PERIOD_METER_MINMAX_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
`endif
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic {WAIT_EDGE, MEASURE} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] counter, high_cnt;
    logic             result, tmo_hit, accept, load, drop;

    // two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_EDGE;
        else     state <= state_nxt;
    end

    // next-state: first rise arms, timeout disarms
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_EDGE: if (rise)    state_nxt = MEASURE;
            MEASURE:   if (tmo_hit) state_nxt = WAIT_EDGE;
            default:                state_nxt = WAIT_EDGE;
        endcase
    end

    // per-edge strobes: a rise while measuring closes a period; a rise beats a timeout
    always_comb begin
        result  = 1'b0;
        tmo_hit = 1'b0;
        if (state == MEASURE) begin
            result  = rise;
            tmo_hit = !rise && (counter == TO_CNT);
        end
        accept = meas_valid && meas_ready;
        load   = result && (!meas_valid || meas_ready);
        drop   = result && meas_valid && !meas_ready;
    end

    // cycle counter and high-time capture; counter stops at TIMEOUT so it never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            high_cnt <= '0;
        end else if (state == WAIT_EDGE) begin
            counter  <= rise ? ONE : '0;
            high_cnt <= '0;
        end else if (rise) begin
            counter  <= ONE;
            high_cnt <= '0;
        end else if (tmo_hit) begin
            counter  <= '0;
        end else begin
            counter  <= counter + ONE;
            if (fall) high_cnt <= counter;
        end
    end

    // result port: hold under backpressure, reload back-to-back on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (load) begin
                meas_valid <= 1'b1;
                period     <= counter;
                high_time  <= high_cnt;
            end else if (accept) begin
                meas_valid <= 1'b0;
            end
            if (drop)        overrun <= 1'b1;
            else if (accept) overrun <= 1'b0;
            if (rise)         timeout <= 1'b0;
            else if (tmo_hit) timeout <= 1'b1;
        end
    end

`ifdef PERIOD_METER_MINMAX_EN
    // min/max over every produced result, dropped ones included; clear then apply
    always_ff @(posedge clk) begin
        if (rst) begin
            min_period <= '1;
            max_period <= '0;
        end else if (stats_clr) begin
            min_period <= result ? counter : '1;
            max_period <= result ? counter : '0;
        end else if (result) begin
            if (counter < min_period) min_period <= counter;
            if (counter > max_period) max_period <= counter;
        end
    end
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (TIMEOUT=16). Input values set at step e are
// first sampled at edge e; results are visible two edges after the sampled rise.
module tb_period_meter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, sig_in, meas_ready;
    logic         meas_valid, timeout, overrun;
    logic [W-1:0] period, high_time;
`ifdef PERIOD_METER_MINMAX_EN
    logic         stats_clr;
    logic [W-1:0] min_period, max_period;
`endif

    int total  = 0;
    int passed = 0;

    period_meter #(.CNT_W(W), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_ready (meas_ready),
`ifdef PERIOD_METER_MINMAX_EN
        .stats_clr  (stats_clr),
        .min_period (min_period),
        .max_period (max_period),
`endif
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .timeout    (timeout),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sig_in = 1'b0; meas_ready = 1'b0;
`ifdef PERIOD_METER_MINMAX_EN
        stats_clr = 1'b0;
`endif
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (meas_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", meas_valid); else passed++;
        total++; if (period !== '0)       $display("FAIL reset_period got=%0d exp=0", period); else passed++;
        total++; if (high_time !== '0)    $display("FAIL reset_high got=%0d exp=0", high_time); else passed++;
        total++; if (timeout !== 1'b0)    $display("FAIL reset_timeout got=%0b exp=0", timeout); else passed++;
        total++; if (overrun !== 1'b0)    $display("FAIL reset_overrun got=%0b exp=0", overrun); else passed++;
    endtask

    // period 4, high 2, always ready: results at edges 6,10,14,...
    task automatic test_basic();
        logic exp_v;
        do_reset();
        meas_ready = 1'b1;
        for (int e = 0; e < 24; e++) begin
            sig_in = ((e % 4) < 2);
            cyc();
            exp_v = (e >= 6) && (e % 4 == 2);
            total++; if (meas_valid !== exp_v) $display("FAIL basic_valid e=%0d got=%0b exp=%0b", e, meas_valid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (period !== 32'd4 || high_time !== 32'd2)
                    $display("FAIL basic_result e=%0d got=%0d/%0d exp=4/2", e, period, high_time); else passed++;
            end
        end
        total++; if (overrun !== 1'b0) $display("FAIL basic_overrun got=%0b exp=0", overrun); else passed++;
    endtask

    // period 10, high 3, no ready: first result held, second dropped
    task automatic test_backpressure();
        logic exp_v, exp_o;
        do_reset();
        for (int e = 0; e < 30; e++) begin
            sig_in = ((e % 10) < 3);
            cyc();
            exp_v = (e >= 12);
            exp_o = (e >= 22);
            total++; if (meas_valid !== exp_v) $display("FAIL bp_valid e=%0d got=%0b exp=%0b", e, meas_valid, exp_v); else passed++;
            total++; if (overrun !== exp_o)    $display("FAIL bp_overrun e=%0d got=%0b exp=%0b", e, overrun, exp_o); else passed++;
            if (exp_v) begin
                total++; if (period !== 32'd10 || high_time !== 32'd3)
                    $display("FAIL bp_hold e=%0d got=%0d/%0d exp=10/3", e, period, high_time); else passed++;
            end
        end
        sig_in = 1'b1; meas_ready = 1'b1;
        cyc();
        meas_ready = 1'b0;
        total++; if (meas_valid !== 1'b0) $display("FAIL bp_accept_valid got=%0b exp=0", meas_valid); else passed++;
        total++; if (overrun !== 1'b0)    $display("FAIL bp_accept_overrun got=%0b exp=0", overrun); else passed++;
    endtask

    // one rise then low: timeout at edge 18; rise at 27 clears; result at 35
    task automatic test_timeout();
        logic exp_t, exp_v;
        do_reset();
        meas_ready = 1'b1;
        for (int e = 0; e < 37; e++) begin
            sig_in = (e < 25) ? (e < 2) : (((e - 25) % 8) < 4);
            cyc();
            exp_t = (e >= 18) && (e < 27);
            exp_v = (e == 35);
            total++; if (timeout !== exp_t)    $display("FAIL to_flag e=%0d got=%0b exp=%0b", e, timeout, exp_t); else passed++;
            total++; if (meas_valid !== exp_v) $display("FAIL to_valid e=%0d got=%0b exp=%0b", e, meas_valid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (period !== 32'd8 || high_time !== 32'd4)
                    $display("FAIL to_result got=%0d/%0d exp=8/4", period, high_time); else passed++;
            end
        end
    endtask

    // reset mid-measurement; first result after reset needs a second rise
    task automatic test_reset_mid();
        logic exp_v;
        do_reset();
        for (int e = 0; e < 13; e++) begin
            sig_in = ((e % 8) < 4);
            cyc();
        end
        total++; if (meas_valid !== 1'b1 || period !== 32'd8)
            $display("FAIL rm_pre got=%0b/%0d exp=1/8", meas_valid, period); else passed++;
        rst = 1'b1; sig_in = 1'b0;
        cyc();
        rst = 1'b0;
        total++; if ({meas_valid, timeout, overrun} !== 3'b000)
            $display("FAIL rm_flags got=%0b exp=000", {meas_valid, timeout, overrun}); else passed++;
        total++; if (period !== '0 || high_time !== '0)
            $display("FAIL rm_fields got=%0d/%0d exp=0/0", period, high_time); else passed++;
        meas_ready = 1'b1;
        for (int e = 14; e < 29; e++) begin
            sig_in = ((e % 8) < 4);
            cyc();
            exp_v = (e == 26);
            total++; if (meas_valid !== exp_v) $display("FAIL rm_valid e=%0d got=%0b exp=%0b", e, meas_valid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (period !== 32'd8 || high_time !== 32'd4)
                    $display("FAIL rm_result got=%0d/%0d exp=8/4", period, high_time); else passed++;
            end
        end
    endtask

    // period equal to TIMEOUT: rise wins over timeout
    task automatic test_coincide();
        logic exp_v;
        do_reset();
        meas_ready = 1'b1;
        for (int e = 0; e < 37; e++) begin
            sig_in = ((e % 16) < 8);
            cyc();
            exp_v = (e == 18) || (e == 34);
            total++; if (timeout !== 1'b0)     $display("FAIL co_timeout e=%0d got=%0b exp=0", e, timeout); else passed++;
            total++; if (meas_valid !== exp_v) $display("FAIL co_valid e=%0d got=%0b exp=%0b", e, meas_valid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (period !== 32'd16 || high_time !== 32'd8)
                    $display("FAIL co_result e=%0d got=%0d/%0d exp=16/8", e, period, high_time); else passed++;
            end
        end
    endtask

    // accept and new result on the same edge: reload, valid stays high, no overrun
    task automatic test_back_to_back();
        do_reset();
        for (int e = 0; e < 15; e++) begin
            sig_in = (e < 2) || (e >= 5 && e < 8) || (e >= 11 && e < 13);
            meas_ready = (e == 13);
            cyc();
            total++; if (meas_valid !== (e >= 7))
                $display("FAIL b2b_valid e=%0d got=%0b exp=%0b", e, meas_valid, (e >= 7)); else passed++;
            if (e == 12) begin
                total++; if (period !== 32'd5 || high_time !== 32'd2)
                    $display("FAIL b2b_first got=%0d/%0d exp=5/2", period, high_time); else passed++;
            end
            if (e == 13) begin
                total++; if (period !== 32'd6 || high_time !== 32'd3)
                    $display("FAIL b2b_second got=%0d/%0d exp=6/3", period, high_time); else passed++;
                total++; if (overrun !== 1'b0)
                    $display("FAIL b2b_overrun got=%0b exp=0", overrun); else passed++;
            end
        end
        meas_ready = 1'b0;
    endtask

`ifdef PERIOD_METER_MINMAX_EN
    // periods 6, 12, 9 then stats_clr
    task automatic test_minmax();
        do_reset();
        total++; if (min_period !== '1 || max_period !== '0)
            $display("FAIL mm_reset got=%0h/%0h exp=ffffffff/0", min_period, max_period); else passed++;
        meas_ready = 1'b1;
        for (int e = 0; e < 31; e++) begin
            sig_in = (e < 2) || (e >= 6 && e < 8) || (e >= 18 && e < 20) || (e >= 27 && e < 29);
            cyc();
            if (e == 8) begin
                total++; if (min_period !== 32'd6 || max_period !== 32'd6)
                    $display("FAIL mm_first got=%0d/%0d exp=6/6", min_period, max_period); else passed++;
            end
        end
        total++; if (min_period !== 32'd6 || max_period !== 32'd12)
            $display("FAIL mm_final got=%0d/%0d exp=6/12", min_period, max_period); else passed++;
        sig_in = 1'b0; stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        total++; if (min_period !== '1 || max_period !== '0)
            $display("FAIL mm_clr got=%0h/%0h exp=ffffffff/0", min_period, max_period); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_coincide();
        test_back_to_back();
`ifdef PERIOD_METER_MINMAX_EN
        test_minmax();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
